// File: rtl/dmem_pkg.sv
// Shared widths, FSM state encoding and port-id type for the data-memory arbiter.
// Compile-time only; no logic, latency or backpressure of its own.
package dmem_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERR,
    RESP
  } state_t;

  typedef logic port_id_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the memory-side strobes.
// slave = arbiter view, master = requesters/memory view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = dmem_pkg::ADDR_W,
  parameter int DATA_W = dmem_pkg::DATA_W
);
  logic              m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr, mem_r;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_addr, mem_wr, mem_r, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_addr, mem_wr, mem_r, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; combinational grant, only while en is high.
// Ties go to the port not granted last; history flop resets to "m1 last".
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || last_q)) gnt[0] = 1'b1;
      else if (req[1])                   gnt[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_q <= 1'b1;
    else if (|gnt) last_q <= gnt[1];
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the big-endian data memory between two requesters: gnt at N, strobe N+1, rvalid N+2.
// One transaction per 3 cycles; requesters hold req until gnt, misaligned words skip memory.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = dmem_pkg::ADDR_W,
  parameter int DATA_W = dmem_pkg::DATA_W
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);
  state_t state_q, state_d;
  logic [1:0] req, gnt;
  logic       arb_en;

  logic              sel_we, aligned;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, rd_word;

  port_id_t          lat_port;
  logic              lat_we;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, m0_rdata_q, m1_rdata_q;
  logic              mem_wr_q, mem_r_q;
  logic              m0_rvalid_q, m1_rvalid_q, m0_err_q, m1_err_q;

  assign req    = {bus.m1_req, bus.m0_req};
  // Gating with rst_n keeps gnt low while reset is held, like every other output.
  assign arb_en = rst_n && (state_q == IDLE);

  rr_arb2 u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .en   (arb_en),
    .gnt  (gnt)
  );

  assign sel_we    = gnt[1] ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = gnt[1] ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = gnt[1] ? bus.m1_wdata : bus.m0_wdata;
  assign aligned   = (sel_addr[1:0] == 2'b00);
  assign rd_word   = (state_q == ACCESS && !lat_we) ? bus.mem_rdata : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (|gnt) state_d = aligned ? ACCESS : ERR;
      ACCESS, ERR: state_d = RESP;
      RESP:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Memory strobes are loaded at grant so they are live for exactly the ACCESS cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_port    <= 1'b0;
      lat_we      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      mem_r_q     <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (|gnt) begin
          lat_port <= gnt[1];
          lat_we   <= sel_we;
          if (aligned) begin
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_wr_q    <= sel_we;
            mem_r_q     <= !sel_we;
          end
        end
        ACCESS, ERR: begin
          mem_wr_q    <= 1'b0;
          mem_r_q     <= 1'b0;
          m0_rvalid_q <= !lat_port;
          m1_rvalid_q <= lat_port;
          m0_err_q    <= (state_q == ERR) && !lat_port;
          m1_err_q    <= (state_q == ERR) && lat_port;
          m0_rdata_q  <= lat_port ? '0 : rd_word;
          m1_rdata_q  <= lat_port ? rd_word : '0;
        end
        RESP: begin
          m0_rvalid_q <= 1'b0;
          m1_rvalid_q <= 1'b0;
          m0_err_q    <= 1'b0;
          m1_err_q    <= 1'b0;
          m0_rdata_q  <= '0;
          m1_rdata_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.m0_err    = m0_err_q;
  assign bus.m1_err    = m1_err_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_r     = mem_r_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory behind the arbiter, transaction-level reference model.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Data memory: big-endian, MSB byte at the word address.
  logic [7:0]  mem [0:4095];
  logic        mem_clr = 1'b1;
  logic [11:0] a0, a1, a2, a3;
  assign a0 = bus.mem_addr;
  assign a1 = bus.mem_addr + 12'd1;
  assign a2 = bus.mem_addr + 12'd2;
  assign a3 = bus.mem_addr + 12'd3;
  assign bus.mem_rdata = bus.mem_r ? {mem[a0], mem[a1], mem[a2], mem[a3]} : '0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (bus.mem_wr) begin
      mem[a0] <= bus.mem_wdata[31:24];
      mem[a1] <= bus.mem_wdata[23:16];
      mem[a2] <= bus.mem_wdata[15:8];
      mem[a3] <= bus.mem_wdata[7:0];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] ref_mem [0:4095];
  txn_t q0[$], q1[$];
  int   last_w = 1;
  int   prev_gnt_cyc = 0;
  bit   expect_b2b = 0;
  int   cyc = 0;
  int   since_gnt = 99;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      check("wr_r_excl", {31'd0, bus.mem_wr & bus.mem_r}, 0);
      check("rvalid_overlap", {31'd0, bus.m0_rvalid & bus.m1_rvalid}, 0);
      since_gnt++;
      if (bus.m0_gnt | bus.m1_gnt) begin
        check("gnt_idle_only", {31'd0, since_gnt >= 3}, 1);
        since_gnt = 0;
      end
    end else begin
      since_gnt = 99;
    end
  end

  function automatic logic [31:0] ref_rd(input logic [11:0] a);
    int b;
    b = int'(a);
    return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
  endfunction

  task automatic drive_heads();
    bus.m0_req = (q0.size() > 0);
    if (q0.size() > 0) begin
      bus.m0_we = q0[0].we; bus.m0_addr = q0[0].addr; bus.m0_wdata = q0[0].wdata;
    end
    bus.m1_req = (q1.size() > 0);
    if (q1.size() > 0) begin
      bus.m1_we = q1[0].we; bus.m1_addr = q1[0].addr; bus.m1_wdata = q1[0].wdata;
    end
  endtask

  function automatic logic [7:0] out_flags();
    return {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid,
            bus.m0_err, bus.m1_err, bus.mem_wr, bus.mem_r};
  endfunction

  task automatic do_txn();
    int n, w, exp_w, b;
    txn_t t;
    logic al;
    logic [31:0] exp_rd;
    n = 0;
    @(negedge clk);
    while (!(bus.m0_gnt | bus.m1_gnt) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("gnt_timeout", 0, 1);
      q0.delete(); q1.delete();
      drive_heads();
      return;
    end
    w = bus.m1_gnt ? 1 : 0;
    exp_w = (q0.size() > 0 && q1.size() > 0) ? 1 - last_w : (q0.size() > 0 ? 0 : 1);
    check("arb_winner", w, exp_w);
    check("gnt_onehot", {31'd0, bus.m0_gnt & bus.m1_gnt}, 0);
    if (expect_b2b) check("gnt_spacing", cyc - prev_gnt_cyc, 3);
    prev_gnt_cyc = cyc;
    last_w = w;
    if (w == 0) t = q0.pop_front();
    else        t = q1.pop_front();
    al = (t.addr[1:0] == 2'b00);
    exp_rd = (!t.we && al) ? ref_rd(t.addr) : 32'd0;
    if (t.we && al) begin
      b = int'(t.addr);
      ref_mem[b]   = t.wdata[31:24];
      ref_mem[b+1] = t.wdata[23:16];
      ref_mem[b+2] = t.wdata[15:8];
      ref_mem[b+3] = t.wdata[7:0];
    end

    @(posedge clk); #1;
    if (w == 0) bus.m0_req = 1'b0;
    else        bus.m1_req = 1'b0;
    @(negedge clk);
    check("acc_wr", {31'd0, bus.mem_wr}, {31'd0, t.we & al});
    check("acc_r", {31'd0, bus.mem_r}, {31'd0, !t.we & al});
    if (al) check("acc_addr", {20'd0, bus.mem_addr}, {20'd0, t.addr});
    if (al && t.we) check("acc_wdata", bus.mem_wdata, t.wdata);
    check("acc_no_rvalid", {31'd0, bus.m0_rvalid | bus.m1_rvalid}, 0);

    // Winner may re-request during its own rvalid cycle.
    @(posedge clk); #1;
    drive_heads();
    @(negedge clk);
    check("resp_rvalid_own", {31'd0, (w == 0) ? bus.m0_rvalid : bus.m1_rvalid}, 1);
    check("resp_rvalid_other", {31'd0, (w == 0) ? bus.m1_rvalid : bus.m0_rvalid}, 0);
    check("resp_rdata", (w == 0) ? bus.m0_rdata : bus.m1_rdata, exp_rd);
    check("resp_err", {31'd0, (w == 0) ? bus.m0_err : bus.m1_err}, {31'd0, !al});
    check("resp_strobes_low", {30'd0, bus.mem_wr, bus.mem_r}, 0);
    if (al) check("resp_addr_hold", {20'd0, bus.mem_addr}, {20'd0, t.addr});
    expect_b2b = (q0.size() > 0 || q1.size() > 0);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    drive_heads();
    expect_b2b = 0;
    while (q0.size() > 0 || q1.size() > 0) do_txn();
  endtask

  function automatic txn_t mk(input logic we, input logic [11:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    @(posedge clk); #1;
    mem_clr = 1'b0;
    #1;
    check("rst_flags", {24'd0, out_flags()}, 0);
    check("rst_addr", {20'd0, bus.mem_addr}, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_rdata", bus.m0_rdata | bus.m1_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_flags", {24'd0, out_flags()}, 0);

    // Basic write then read-back on m0
    q0.push_back(mk(1'b1, 12'h010, 32'hDEADBEEF));
    q0.push_back(mk(1'b0, 12'h010, 32'h0));
    drain();

    // m1 write, then misaligned m0 read
    q1.push_back(mk(1'b1, 12'h020, 32'h11223344));
    drain();
    q0.push_back(mk(1'b0, 12'h021, 32'h0));
    drain();

    // Both requesters held continuously: grants alternate every 3 cycles
    q0.push_back(mk(1'b1, 12'h040, 32'hA0A0A0A0));
    q0.push_back(mk(1'b0, 12'h044, 32'h0));
    q1.push_back(mk(1'b1, 12'h044, 32'hB1B1B1B1));
    q1.push_back(mk(1'b0, 12'h040, 32'h0));
    drain();

    // Top of memory and misaligned near the top
    q0.push_back(mk(1'b1, 12'hFFC, 32'hCAFEF00D));
    q0.push_back(mk(1'b0, 12'hFFC, 32'h0));
    q0.push_back(mk(1'b0, 12'hFFE, 32'h0));
    drain();

    // Reset in the ACCESS cycle of a read
    q0.push_back(mk(1'b0, 12'h010, 32'h0));
    @(posedge clk); #1;
    drive_heads();
    @(negedge clk);
    check("rst_mid_gnt", {31'd0, bus.m0_gnt}, 1);
    @(posedge clk); #1;
    bus.m0_req = 1'b0;
    q0.delete();
    check("rst_mid_pre_r", {31'd0, bus.mem_r}, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_flags", {24'd0, out_flags()}, 0);
    check("rst_mid_addr", {20'd0, bus.mem_addr}, 0);
    check("rst_mid_rdata", bus.m0_rdata | bus.m1_rdata, 0);
    last_w = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_rvalid", {31'd0, bus.m0_rvalid | bus.m1_rvalid}, 0);
    end
    q0.push_back(mk(1'b0, 12'hFFC, 32'h0));
    q1.push_back(mk(1'b0, 12'h020, 32'h0));
    drain();

    // Randomized traffic over a small window so reads hit earlier writes
    for (int r = 0; r < 40; r++) begin
      int n0, n1;
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      for (int k = 0; k < n0 + n1; k++) begin
        logic [11:0] a;
        a = {6'd0, 4'($urandom_range(0, 15)), 2'b00};
        if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
        if (k < n0) q0.push_back(mk(1'($urandom_range(0, 1)), a, $urandom));
        else        q1.push_back(mk(1'($urandom_range(0, 1)), a, $urandom));
      end
      drain();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Sequences and shares the 4 KB byte-addressed, big-endian data memory between two requesters:
  - m0: load/store unit.
  - m1: debug/DMA loader.
- Arbitrates 2-way round-robin.
- Registers each word request and drives the memory's addr/wr/r/data_in strobes for exactly one cycle.
- Captures read data and returns a one-cycle response pulse.
- Rejects misaligned word accesses without touching memory.

## Interface
Parameters:
- ADDR_W, 12, byte address width (4 KB).
- DATA_W, 32, word width. Memory stores MSB byte at addr.

Ports:
- Clocking:
  - clk  in  1  single clock, rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
- Requester m0:
  - m0_req  in  1  request. Held with fields stable until m0_gnt.
  - m0_we  in  1  1 = write, 0 = read.
  - m0_addr  in  ADDR_W  byte address.
  - m0_wdata  in  DATA_W  write data.
  - m0_gnt  out  1  request accepted (combinational, IDLE only).
  - m0_rvalid  out  1  one-cycle response pulse.
  - m0_rdata  out  DATA_W  read data. Valid with m0_rvalid, 0 for writes and errors.
  - m0_err  out  1  misaligned access. Valid with m0_rvalid.
- Requester m1: m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err, identical to m0.
- Memory side:
  - mem_addr  out  ADDR_W  to memory addr.
  - mem_wr  out  1  to memory wr.
  - mem_r  out  1  to memory r.
  - mem_wdata  out  DATA_W  to memory data_in.
  - mem_rdata  in  DATA_W  from memory data_out. Tri-stated when mem_r=0.

## Operation
FSM states:
- IDLE:
  - If any req is high, the arbiter picks a winner and asserts its gnt this cycle.
  - Latches we/addr/wdata/port id.
  - Next state: ERR if addr[1:0]≠0, else ACCESS.
  - With no req, stays in IDLE.
- ACCESS:
  - mem_wr = latched we, mem_r = !latched we.
  - mem_addr and mem_wdata come from the latch.
  - For reads, mem_rdata is registered at the end of the cycle.
  - Next state: RESP.
- ERR: no memory strobes. Next state: RESP with err flag set.
- RESP:
  - rvalid=1 on the latched port only.
  - rdata = captured word for reads, 0 for writes and errors.
  - Next state: IDLE.

Arbitration rules:
- Only one requester high: it wins.
- Both high: the port not granted last wins.
- After reset, last-granted = m1, so m0 wins the first tie.

Invariants and boundary conditions:
- mem_wr and mem_r are never high together. Both are 0 outside ACCESS.
- mem_addr and mem_wdata hold their last value outside ACCESS, 0 after reset.
- Aligned addresses only reach memory, so addr+3 never wraps past 0xFFF. The highest legal word is at 0xFFC.
- Requests arriving during ACCESS/ERR/RESP wait. gnt is never asserted outside IDLE.
- A requester may re-assert req in the cycle of its own rvalid. It is sampled in the following IDLE.
- A requester dropping req before gnt is legal. Nothing is latched.
- Reset mid-transaction:
  - FSM returns to IDLE immediately (asynchronous).
  - All outputs go to 0 and the in-flight transaction is dropped.
  - No rvalid is issued.
  - A write in ACCESS may be partially applied; software must tolerate this.

## Timing
- Reset values: every output 0, state IDLE, last-granted = m1, capture registers 0.
- Accepted at cycle N (gnt high) → memory strobe at N+1 → rvalid at N+2.
- Throughput: one transaction per 3 cycles. Back-to-back grants at N and N+3.
- Error path has the same latency: gnt at N, rvalid+err at N+2.
- gnt is combinational from req and state. All other outputs are registered.

## Structure
- Package dmem_pkg:
  - ADDR_W and DATA_W constants.
  - State enum {IDLE, ACCESS, ERR, RESP}.
  - Port-id typedef (1 bit).
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], en (IDLE).
  - Outputs: gnt[1:0] (one-hot or zero).
  - Owns the last-granted flop, updated only on a grant.
- Remaining FSM, request latch, and response registers stay in dmem_arbiter.
- Integration test instantiates dmem_arbiter with the existing data memory.

## Test plan
- Reset, then m0 writes 0xDEADBEEF at 0x010, then m0 reads 0x010 → mem_wr high exactly one cycle. Read rvalid at gnt+2 with rdata 0xDEADBEEF, err 0.
- m1 writes 0x11223344 at 0x020, then m0 reads 0x021 (misaligned) → m0_gnt then m0_rvalid with m0_err=1, rdata 0. mem_r/mem_wr stay 0 throughout.
- m0 and m1 both hold req continuously for 4 transactions → grants alternate m0, m1, m0, m1 at cycles N, N+3, N+6, N+9. The m1_rvalid/m0_rvalid pulses never overlap.
- Write 0xCAFEF00D at 0xFFC, read back → rdata 0xCAFEF00D. A read at 0xFFE is rejected with err=1.
- Assert rst_n low during ACCESS of a read → all outputs 0 asynchronously and no rvalid after release. The next request completes normally with m0 winning the tie.
- Throughout all tests, assert: mem_wr&mem_r never true, gnt only in IDLE, at most one rvalid per cycle.
